// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared types and constants for the convolution processing element
package pe_pkg;

  // MAC sequencer states
  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    MAC,
    STORE
  } state_t;

  // Filter-bank modes; any mode with bit 1 set behaves as single filter
  localparam logic [1:0] MODE_SINGLE = 2'b00;
  localparam logic [1:0] MODE_MULTI  = 2'b01;

  // Row marker bits sit directly above the IFM payload words
  localparam int MARK_END_OFS   = 0;
  localparam int MARK_START_OFS = 1;

endpackage

// File: rtl/pe_fifo.sv
// rtl/pe_fifo.sv - synchronous first-word-fall-through FIFO with clear
module pe_fifo #(
  parameter int WIDTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [1<<AW];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty   = (wptr == rptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr[AW-1:0]];

  // Storage array, written only on an accepted push
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

  // Pointer update; clear empties the FIFO regardless of push/pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else if (clr) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/pe.sv
// rtl/pe.sv - row-stationary convolution processing element with one signed MAC
module pe
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH_IFM = 4,
  parameter int ADDR_WIDTH_FIL = 5,
  parameter int S              = 3,
  parameter int F              = 3,
  parameter int PAR_WRITE      = 1,
  parameter int PAR_READ       = 1,
  parameter int FIL_DEPTH      = 3
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic                                   r_en,
  input  logic                                   w_en_ifm,
  input  logic                                   w_en_fil,
  input  logic                                   w_en_psum,
  input  logic                                   acum,
  input  logic [DATA_WIDTH*PAR_WRITE+1:0]        data_in_ifm,
  input  logic [DATA_WIDTH*PAR_WRITE-1:0]        data_in_fil,
  input  logic [DATA_WIDTH-1:0]                  data_in_psum,
  input  logic [S-1:0]                           stride,
  input  logic [F-1:0]                           filter_size,
  input  logic [1:0]                             mode,
  output logic [(2*DATA_WIDTH-1)*PAR_READ-1:0]   out,
  output logic                                   done,
  output logic                                   valid,
  output logic                                   ready_ifm,
  output logic                                   ready_fil,
  output logic                                   ready_psum
);

  localparam int ACC_W = 2*DATA_WIDTH-1;
  localparam int AI    = ADDR_WIDTH_IFM;
  localparam int AF    = ADDR_WIDTH_FIL;
  localparam int IPW   = AI+1;
  localparam int FCW   = AF+1;
  localparam int PW    = DATA_WIDTH*PAR_WRITE;
  localparam int FW    = (FIL_DEPTH > 1) ? $clog2(FIL_DEPTH) : 1;
  localparam int CW    = AI+3;
  localparam int ROW_W = 2*IPW;

  // Configuration latched while start is high
  logic             started;
  logic [S-1:0]     stride_r;
  logic [F-1:0]     k_r;
  logic             multi_r;
  logic             acum_r;
  logic [FCW-1:0]   fil_need;

  // Buffers and pointers
  logic [DATA_WIDTH-1:0] fil_mem [1<<AF];
  logic [DATA_WIDTH-1:0] ifm_mem [1<<AI];
  logic [FCW-1:0]   fil_cnt;
  logic [IPW-1:0]   wr_ptr;
  logic [IPW-1:0]   free_ptr;
  logic [IPW-1:0]   cur_base;
  logic [IPW-1:0]   ifm_used;
  logic             ovf;
  logic             rows_seen;

  // Sequencer and datapath registers
  state_t           state;
  state_t           state_nxt;
  logic [AI-1:0]    base_r;
  logic [IPW-1:0]   len_r;
  logic [IPW-1:0]   pos_r;
  logic [F-1:0]     tap_r;
  logic [FW-1:0]    filt_r;
  logic [AF-1:0]    fil_base_r;
  logic [ACC_W-1:0] acc_r;

  // Handshake and control strobes
  logic             active;
  logic             fil_acc;
  logic             ifm_acc;
  logic             psum_acc;
  logic             mark_start;
  logic             mark_end;
  logic [IPW-1:0]   len_now;
  logic             fil_loaded;
  logic             row_push;
  logic             row_pop;
  logic [ROW_W-1:0] row_din;
  logic [ROW_W-1:0] row_head;
  logic [IPW-1:0]   row_end_next;
  logic [IPW-1:0]   row_len;
  logic             row_full;
  logic             row_empty;
  logic             row_fits;
  logic             next_fits;
  logic             last_tap;
  logic             last_filter;
  logic             start_row;
  logic             free_row;
  logic             mac_step;
  logic             next_filter;
  logic             next_window;
  logic             out_push;
  logic             out_pop;
  logic             out_full;
  logic             out_empty;
  logic [ACC_W-1:0] out_head;
  logic             psum_pop;
  logic             psum_full;
  logic             psum_empty;
  logic [DATA_WIDTH-1:0] psum_head;

  // Datapath arithmetic
  logic [AI-1:0]         ifm_addr;
  logic [AF-1:0]         fil_addr;
  logic [DATA_WIDTH-1:0] ifm_word;
  logic [DATA_WIDTH-1:0] fil_word;
  logic [ACC_W-1:0]      prod;
  logic [ACC_W-1:0]      mac_sum;
  logic [ACC_W-1:0]      psum_ext;
  logic [ACC_W-1:0]      store_val;

  assign active     = started && !start;
  assign ifm_used   = wr_ptr - free_ptr;
  assign fil_loaded = (fil_cnt == fil_need);
  assign ready_fil  = active && (fil_cnt < fil_need);
  assign ready_ifm  = active && !ifm_used[AI] && !ovf && !row_full;
  assign ready_psum = active && !psum_full;
  assign fil_acc    = w_en_fil && ready_fil;
  assign ifm_acc    = w_en_ifm && ready_ifm;
  assign psum_acc   = w_en_psum && ready_psum;

  assign mark_start = data_in_ifm[PW + MARK_START_OFS];
  assign mark_end   = data_in_ifm[PW + MARK_END_OFS];
  assign len_now    = mark_start ? IPW'(1) : (wr_ptr - cur_base + IPW'(1));
  assign row_push   = ifm_acc && mark_end;
  assign row_din    = {wr_ptr + IPW'(1), len_now};

  assign row_end_next = row_head[ROW_W-1:IPW];
  assign row_len      = row_head[IPW-1:0];
  assign row_fits     = (k_r != '0) && (CW'(row_len) >= CW'(k_r));
  assign next_fits    = ({2'b00, pos_r} + CW'(stride_r) + CW'(k_r)) <= {2'b00, len_r};
  assign last_tap     = (tap_r == k_r - F'(1));
  assign last_filter  = !multi_r || (filt_r == FW'(FIL_DEPTH-1));

  assign ifm_addr  = base_r + pos_r[AI-1:0] + AI'(tap_r);
  assign fil_addr  = fil_base_r + AF'(tap_r);
  assign ifm_word  = ifm_mem[ifm_addr];
  assign fil_word  = fil_mem[fil_addr];
  assign prod      = ACC_W'($signed(ifm_word) * $signed(fil_word));
  assign mac_sum   = acc_r + prod;
  assign psum_ext  = {{(ACC_W-DATA_WIDTH){psum_head[DATA_WIDTH-1]}}, psum_head};
  assign store_val = acc_r + (acum_r ? psum_ext : '0);

  assign out_pop = r_en && !out_empty && !start;
  assign done    = (state == WAIT) && row_empty && rows_seen;

  // Descriptor per completed row: pointer past its last word and its length
  pe_fifo #(.WIDTH(ROW_W), .AW(AI)) u_rows (
    .clk(clk), .rst(rst), .clr(start),
    .push(row_push), .din(row_din), .pop(row_pop), .dout(row_head),
    .full(row_full), .empty(row_empty)
  );

  pe_fifo #(.WIDTH(DATA_WIDTH), .AW(AI)) u_psum (
    .clk(clk), .rst(rst), .clr(start),
    .push(psum_acc), .din(data_in_psum), .pop(psum_pop), .dout(psum_head),
    .full(psum_full), .empty(psum_empty)
  );

  pe_fifo #(.WIDTH(ACC_W), .AW(AI)) u_out (
    .clk(clk), .rst(rst), .clr(start),
    .push(out_push), .din(store_val), .pop(out_pop), .dout(out_head),
    .full(out_full), .empty(out_empty)
  );

  // Filter scratchpad, filled in order; filter f tap i at f*K+i
  always_ff @(posedge clk) begin
    if (fil_acc) fil_mem[fil_cnt[AF-1:0]] <= data_in_fil[DATA_WIDTH-1:0];
  end

  // Circular IFM scratchpad
  always_ff @(posedge clk) begin
    if (ifm_acc) ifm_mem[wr_ptr[AI-1:0]] <= data_in_ifm[DATA_WIDTH-1:0];
  end

  // State register; start parks the sequencer in IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        state <= IDLE;
    else if (start) state <= IDLE;
    else            state <= state_nxt;
  end

  // Next-state and datapath strobes for the MAC sequencer
  always_comb begin
    state_nxt   = state;
    row_pop     = 1'b0;
    start_row   = 1'b0;
    free_row    = 1'b0;
    mac_step    = 1'b0;
    out_push    = 1'b0;
    psum_pop    = 1'b0;
    next_filter = 1'b0;
    next_window = 1'b0;
    case (state)
      IDLE: begin
        if (started) state_nxt = WAIT;
      end
      WAIT: begin
        if (fil_loaded && !row_empty) begin
          if (row_fits) begin
            start_row = 1'b1;
            state_nxt = MAC;
          end else begin
            row_pop  = 1'b1;
            free_row = 1'b1;
          end
        end
      end
      MAC: begin
        mac_step = 1'b1;
        if (last_tap) state_nxt = STORE;
      end
      STORE: begin
        if (!out_full && !(acum_r && psum_empty)) begin
          out_push = 1'b1;
          psum_pop = acum_r;
          if (!last_filter) begin
            next_filter = 1'b1;
            state_nxt   = MAC;
          end else if (next_fits) begin
            next_window = 1'b1;
            state_nxt   = MAC;
          end else begin
            row_pop   = 1'b1;
            free_row  = 1'b1;
            state_nxt = WAIT;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Configuration, buffer pointers and MAC datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      started    <= 1'b0;
      stride_r   <= '0;
      k_r        <= '0;
      multi_r    <= 1'b0;
      acum_r     <= 1'b0;
      fil_need   <= '0;
      fil_cnt    <= '0;
      wr_ptr     <= '0;
      free_ptr   <= '0;
      cur_base   <= '0;
      ovf        <= 1'b0;
      rows_seen  <= 1'b0;
      base_r     <= '0;
      len_r      <= '0;
      pos_r      <= '0;
      tap_r      <= '0;
      filt_r     <= '0;
      fil_base_r <= '0;
      acc_r      <= '0;
    end else if (start) begin
      started    <= 1'b1;
      stride_r   <= (stride == '0) ? S'(1) : stride;
      k_r        <= filter_size;
      multi_r    <= (mode == MODE_MULTI);
      acum_r     <= acum;
      fil_need   <= (mode == MODE_MULTI) ? FCW'(FIL_DEPTH) * FCW'(filter_size) : FCW'(filter_size);
      fil_cnt    <= '0;
      wr_ptr     <= '0;
      free_ptr   <= '0;
      cur_base   <= '0;
      ovf        <= 1'b0;
      rows_seen  <= 1'b0;
      base_r     <= '0;
      len_r      <= '0;
      pos_r      <= '0;
      tap_r      <= '0;
      filt_r     <= '0;
      fil_base_r <= '0;
      acc_r      <= '0;
    end else begin
      if (fil_acc) fil_cnt <= fil_cnt + FCW'(1);
      if (ifm_acc) begin
        wr_ptr <= wr_ptr + IPW'(1);
        if (mark_end)        cur_base <= wr_ptr + IPW'(1);
        else if (mark_start) cur_base <= wr_ptr;
        // A row that fills the whole buffer without ending can never complete
        if (!mark_end && (len_now == IPW'(1 << AI))) ovf <= 1'b1;
      end
      if (free_row) begin
        free_ptr  <= row_end_next;
        rows_seen <= 1'b1;
      end
      if (start_row) begin
        base_r     <= row_end_next[AI-1:0] - row_len[AI-1:0];
        len_r      <= row_len;
        pos_r      <= '0;
        tap_r      <= '0;
        filt_r     <= '0;
        fil_base_r <= '0;
        acc_r      <= '0;
      end
      if (mac_step) begin
        acc_r <= mac_sum;
        tap_r <= tap_r + F'(1);
      end
      if (next_filter) begin
        filt_r     <= filt_r + FW'(1);
        fil_base_r <= fil_base_r + AF'(k_r);
        tap_r      <= '0;
        acc_r      <= '0;
      end
      if (next_window) begin
        pos_r      <= pos_r + IPW'(stride_r);
        filt_r     <= '0;
        fil_base_r <= '0;
        tap_r      <= '0;
        acc_r      <= '0;
      end
    end
  end

  // Output register: a pop loads the FIFO head and flags it for one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out   <= '0;
      valid <= 1'b0;
    end else begin
      valid <= out_pop;
      if (out_pop) out <= ((2*DATA_WIDTH-1)*PAR_READ)'(out_head);
    end
  end

endmodule

// File: tb/tb_pe.sv
// tb/tb_pe.sv - scoreboard bench for the convolution processing element
module tb_pe;

  localparam int DW = 16;
  localparam int RW = 2*DW-1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          r_en;
  logic          w_en_ifm;
  logic          w_en_fil;
  logic          w_en_psum;
  logic          acum;
  logic [DW+1:0] data_in_ifm;
  logic [DW-1:0] data_in_fil;
  logic [DW-1:0] data_in_psum;
  logic [2:0]    stride;
  logic [2:0]    filter_size;
  logic [1:0]    mode;
  logic [RW-1:0] out;
  logic          done;
  logic          valid;
  logic          ready_ifm;
  logic          ready_fil;
  logic          ready_psum;

  int            checks = 0;
  int            errors = 0;
  int            popped = 0;
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] mon_exp;

  always #5 clk = ~clk;

  pe dut (
    .clk(clk), .rst(rst), .start(start), .r_en(r_en),
    .w_en_ifm(w_en_ifm), .w_en_fil(w_en_fil), .w_en_psum(w_en_psum), .acum(acum),
    .data_in_ifm(data_in_ifm), .data_in_fil(data_in_fil), .data_in_psum(data_in_psum),
    .stride(stride), .filter_size(filter_size), .mode(mode),
    .out(out), .done(done), .valid(valid),
    .ready_ifm(ready_ifm), .ready_fil(ready_fil), .ready_psum(ready_psum)
  );

  // Monitor: every valid pulse consumes the oldest expected result
  always @(negedge clk) begin
    if (valid) begin
      popped++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result actual=%0d required=none", $signed(out));
      end else begin
        mon_exp = exp_q.pop_front();
        if (out !== mon_exp) begin
          errors++;
          $display("FAIL result actual=%0d required=%0d", $signed(out), $signed(mon_exp));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=handshake", name);
  endtask

  task automatic push_exp(input int v);
    exp_q.push_back(v[RW-1:0]);
  endtask

  task automatic do_start(input logic [1:0] m, input int k, input int s, input logic a);
    start = 1'b1;
    mode = m;
    filter_size = k[2:0];
    stride = s[2:0];
    acum = a;
    tick();
    tick();
    start = 1'b0;
    tick();
  endtask

  task automatic write_fil(input int v);
    int n;
    n = 0;
    data_in_fil = v[DW-1:0];
    w_en_fil = 1'b1;
    while (!ready_fil && n < 50) begin tick(); n++; end
    if (n >= 50) timeout("fil_write");
    tick();
    w_en_fil = 1'b0;
  endtask

  task automatic write_ifm(input int v, input logic s, input logic e);
    int n;
    n = 0;
    data_in_ifm = {s, e, v[DW-1:0]};
    w_en_ifm = 1'b1;
    while (!ready_ifm && n < 50) begin tick(); n++; end
    if (n >= 50) timeout("ifm_write");
    tick();
    w_en_ifm = 1'b0;
  endtask

  task automatic write_psum(input int v);
    int n;
    n = 0;
    data_in_psum = v[DW-1:0];
    w_en_psum = 1'b1;
    while (!ready_psum && n < 50) begin tick(); n++; end
    if (n >= 50) timeout("psum_write");
    tick();
    w_en_psum = 1'b0;
  endtask

  // Row of n words: first + i*inc, marked start on word 0 and end on the last
  task automatic write_row(input int first, input int n, input int inc);
    for (int i = 0; i < n; i++)
      write_ifm(first + i*inc, i == 0, i == n-1);
  endtask

  task automatic write_fil3(input int a, input int b, input int c);
    write_fil(a);
    write_fil(b);
    write_fil(c);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 400) begin tick(); n++; end
    check("done", done, 1);
  endtask

  task automatic drain(input int cnt);
    int target;
    int cyc;
    target = popped + cnt;
    cyc = 0;
    r_en = 1'b1;
    while (popped < target && cyc < 400) begin tick(); cyc++; end
    r_en = 1'b0;
    tick();
    tick();
    if (cyc >= 400) timeout("drain");
    check("queue_empty", exp_q.size(), 0);
  endtask

  task automatic pop_single();
    r_en = 1'b1;
    tick();
    r_en = 1'b0;
    check("valid_pulse", valid, 1);
    tick();
    check("valid_one_cycle", valid, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; r_en = 1'b0;
    w_en_ifm = 1'b0; w_en_fil = 1'b0; w_en_psum = 1'b0; acum = 1'b0;
    data_in_ifm = '0; data_in_fil = '0; data_in_psum = '0;
    stride = '0; filter_size = '0; mode = '0;
    tick(); tick(); tick();
    check("rst_out", out, 0);
    check("rst_valid", valid, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    tick(); tick();
    check("pre_start_ready_ifm", ready_ifm, 0);
    check("pre_start_ready_fil", ready_fil, 0);
    check("pre_start_ready_psum", ready_psum, 0);

    // Single filter [1,2,3], stride 1, row 1..6 with individual pops
    foreach (exp_q[i]) ; // keep queue untouched
    push_exp(14); push_exp(20); push_exp(26); push_exp(32);
    start = 1'b1; mode = 2'b00; filter_size = 3'd3; stride = 3'd1; acum = 1'b0;
    tick();
    check("ready_fil_during_start", ready_fil, 0);
    tick();
    start = 1'b0;
    tick();
    check("ready_fil_after_start", ready_fil, 1);
    check("ready_ifm_after_start", ready_ifm, 1);
    write_fil3(1, 2, 3);
    check("fil_loaded_ready_low", ready_fil, 0);
    write_row(1, 6, 1);
    wait_done();
    for (int i = 0; i < 4; i++) pop_single();
    check("t1_queue_empty", exp_q.size(), 0);

    // Filter completes after two rows are buffered
    push_exp(14); push_exp(20); push_exp(26); push_exp(32);
    push_exp(20); push_exp(26); push_exp(32); push_exp(38);
    do_start(2'b00, 3, 1, 1'b0);
    write_fil(1);
    write_fil(2);
    write_row(1, 6, 1);
    write_row(2, 6, 1);
    tick(); tick();
    check("no_done_before_filter", done, 0);
    write_fil(3);
    wait_done();
    drain(8);

    // Stride 2
    push_exp(14); push_exp(26);
    do_start(2'b00, 3, 2, 1'b0);
    write_fil3(1, 2, 3);
    write_row(1, 6, 1);
    wait_done();
    drain(2);

    // Stride 4, then a row shorter than the filter
    push_exp(14);
    do_start(2'b00, 3, 4, 1'b0);
    write_fil3(1, 2, 3);
    write_row(1, 6, 1);
    drain(1);
    write_row(1, 2, 1);
    wait_done();
    tick(); tick();
    check("short_row_no_result", exp_q.size(), 0);

    // Psum accumulate: stalls until psums are supplied; empty pops keep out
    do_start(2'b00, 3, 1, 1'b1);
    write_fil3(1, 2, 3);
    write_row(1, 6, 1);
    repeat (20) tick();
    check("stall_done_low", done, 0);
    r_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("empty_pop_valid", valid, 0);
      check("empty_pop_out_hold", out, 14);
    end
    r_en = 1'b0;
    push_exp(114); push_exp(220); push_exp(326); push_exp(432);
    write_psum(100); write_psum(200); write_psum(300); write_psum(400);
    drain(4);
    wait_done();

    // Three filters, window-major / filter-minor ordering
    push_exp(6); push_exp(3); push_exp(-1); push_exp(9); push_exp(4); push_exp(-2);
    do_start(2'b01, 3, 1, 1'b0);
    write_fil3(1, 1, 1);
    write_fil3(0, 0, 1);
    write_fil3(-1, 0, 0);
    check("multi_fil_loaded", ready_fil, 0);
    write_row(1, 4, 1);
    wait_done();
    drain(6);

    // Most-negative operands: 3 * 2^30 wraps in 31 bits to 0x40000000
    push_exp(32'h4000_0000);
    do_start(2'b00, 3, 1, 1'b0);
    write_fil3(-32768, -32768, -32768);
    write_row(-32768, 3, 0);
    wait_done();
    drain(1);

    // Reset asserted mid-MAC clears outputs at once
    do_start(2'b00, 7, 1, 1'b0);
    for (int i = 0; i < 7; i++) write_fil(1);
    write_row(1, 7, 1);
    tick(); tick();
    rst = 1'b1;
    #1;
    check("mid_rst_out", out, 0);
    check("mid_rst_valid", valid, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_ready_ifm", ready_ifm, 0);
    check("mid_rst_ready_fil", ready_fil, 0);
    check("mid_rst_ready_psum", ready_psum, 0);
    tick();
    rst = 1'b0;
    tick(); tick();
    check("post_rst_ready_fil", ready_fil, 0);
    check("final_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe.md
Name: pe

Overview:
- Convolution processing element for a row-stationary accelerator array; filter, input-feature-map (IFM) and partial-sum (psum) scratchpads feed one signed multiply-accumulate (MAC) datapath.
- Computes 1-D convolutions of marker-delimited IFM rows against filter_size-tap filters, with configurable stride and an optional psum add.
- Results enter an output FIFO and are popped by r_en.

Parameters:
- DATA_WIDTH, 16, signed operand width.
- ADDR_WIDTH_IFM, 4, log2 depth of the IFM buffer (16 words); also sizes the output FIFO and the psum FIFO.
- ADDR_WIDTH_FIL, 5, log2 depth of the filter buffer (32 words).
- S, 3, stride field width.
- F, 3, filter_size field width.
- PAR_WRITE, 1, words per IFM/filter write beat.
- PAR_READ, 1, results per output pop.
- FIL_DEPTH, 3, number of filters held in mode 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  level; while high, latches config, clears all buffers/pointers and flags.
- r_en  in  1  pop output FIFO.
- w_en_ifm  in  1  IFM write strobe.
- w_en_fil  in  1  filter write strobe.
- w_en_psum  in  1  psum write strobe.
- acum  in  1  add psum to each result; latched while start is high.
- data_in_ifm  in  DATA_WIDTH*PAR_WRITE+2  bit[MSB] = row start, bit[MSB-1] = row end, low bits = PAR_WRITE words, word 0 first.
- data_in_fil  in  DATA_WIDTH*PAR_WRITE  filter words.
- data_in_psum  in  DATA_WIDTH  signed psum.
- stride  in  S  window step; latched at start.
- filter_size  in  F  taps K; latched at start.
- mode  in  2  00 single filter; 01 FIL_DEPTH filters; 1x treated as 00. Latched at start.
- out  out  (2*DATA_WIDTH-1)*PAR_READ  popped result(s), result 0 in the low bits.
- done  out  1  all complete rows processed.
- valid  out  1  out holds fresh data.
- ready_ifm  out  1  IFM buffer can accept a beat.
- ready_fil  out  1  filter buffer can accept a beat.
- ready_psum  out  1  psum FIFO not full.

Behaviour:
- Reset: all outputs 0, all buffers empty, state IDLE.
  - ready_* stay 0 until the first start.
- start high: clears buffers and done; readies assert the cycle after start falls.
  - start takes priority over all other inputs.
- Writes: take effect only when w_en_x && ready_x.
  - One accepted beat per cycle per buffer; a held strobe writes every cycle.
- Filter buffer:
  - Loading completes after NF = K (mode 00) or FIL_DEPTH*K (mode 01) words; words beyond NF are dropped.
  - ready_fil is low once NF words are loaded.
  - Filter f, tap i lives at address f*K+i.
- IFM buffer: circular, 16 words; ready_ifm is low when full.
  - A row is complete when a word with the end bit is accepted.
  - A start bit resets the row's base to that word.
  - Rows longer than the buffer are unsupported: ready_ifm stays low until the next start.
- Compute runs when the filter is loaded and at least one complete row exists. Row length L, windows W = floor((L-K)/S)+1; W = 0 if L < K or K = 0.
- Stride 0 is treated as 1.
- Result j, filter f: sum over i = 0..K-1 of ifm[base+j*S+i]*fil[f*K+i].
  - Signed, accumulated and wrapped at 2*DATA_WIDTH-1 bits.
  - If acum, the sign-extended next psum FIFO entry is added.
- Output order: window-major, filter-minor (mode 01).
- After a row's last result, the row's words are freed from the IFM buffer.
  - The filter stays loaded for subsequent rows.
- FSM states:
  - IDLE → WAIT after start.
  - WAIT → MAC when a row is ready.
  - MAC runs K cycles, one tap per cycle.
  - MAC → STORE, which writes the result to the output FIFO.
  - STORE → MAC for the next window/filter, or → WAIT at row end.
- STORE stalls while the output FIFO is full, or (acum) while the psum FIFO is empty.
- Latency: a result enters the FIFO K+1 cycles after MAC begins.
- Output pop: r_en with the FIFO non-empty registers the head to out; valid = 1 the next cycle for exactly one cycle.
  - r_en held N cycles pops up to N entries.
  - r_en on an empty FIFO gives valid = 0; out holds its last value.
- done = 1 in WAIT with no complete row pending and at least one row processed since start; cleared by start or by a new row completing.

Decomposition:
- Package pe_pkg: FSM state enum (IDLE, WAIT, MAC, STORE), mode constants, marker bit positions.
- One sub-module pe_fifo (parameterised width/depth, full/empty), used for the psum and output FIFOs.

Test Plan:
- Mode 00, K=3, S=1, filter [1,2,3], row [1,2,3,4,5,6] → pops 14,20,26,32, each with a one-cycle valid pulse; then done = 1.
- Same, but the filter's third word arrives after two rows [1..6] and [2..7] → 8 results: 14,20,26,32 then 20,26,32,38.
- S=2, same row → 14,26; S=4 → 14 only; row of 2 words → no results, done = 1.
- acum=1 with psum 100,200,300,400 → 114,220,326,432; with the psum FIFO empty, no result appears until the psum is written.
- Mode 01, FIL_DEPTH=3, K=3, filters [1,1,1],[0,0,1],[-1,0,0], row [1..4] → 6,3,-1,9,4,-2.
- Extremes: filter [-32768,...] with IFM -32768 wraps at 31 bits. Holding r_en on an empty FIFO gives valid = 0. Asserting rst mid-MAC clears all outputs immediately.
